// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator with a run-time reprogrammable mode.
// The counters advance only on pix_en, so the block can run from a clock
// faster than the pixel rate.
//
// Optional feature macro: VGA_TIMING_GEN_CFG_EN
//   defined   : pending-mode register, valid/ready handshake and rejection
//               check are built; a new mode is applied at the next frame start.
//   undefined : timing is fixed to the parameters, cfg_ready/cfg_err are 0
//               and all cfg_* inputs are ignored.
//
// Ports
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   pix_en                  : pixel tick; counters advance only when high
//   cfg_h_* / cfg_v_*       : new horizontal / vertical timing fields
//   cfg_h_neg / cfg_v_neg   : new sync polarities (1 = active-low)
//   cfg_valid / cfg_ready   : mode-load handshake
//   cfg_err                 : one-clock pulse, the transferred mode was rejected
//   hsync, vsync            : sync outputs with polarity applied
//   picture                 : current (x, y) lies in the active area
//   x, y                    : current position
//   line_start, frame_start : one-clock strobes on entering x = 0 / (0, 0)
//   frame_count             : number of frame starts, wraps at 16 bits
module vga_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit H_NEG    = 1'b0,
    parameter bit V_NEG    = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_en,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_h_neg,
    input  logic          cfg_v_neg,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          picture,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    typedef struct packed {
        logic [CW-1:0] h_active;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_active;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
        logic          h_neg;
        logic          v_neg;
    } timing_t;

    localparam timing_t PARAM_CFG = '{
        h_active: CW'(H_ACTIVE), h_fp: CW'(H_FP), h_sync: CW'(H_SYNC), h_bp: CW'(H_BP),
        v_active: CW'(V_ACTIVE), v_fp: CW'(V_FP), v_sync: CW'(V_SYNC), v_bp: CW'(V_BP),
        h_neg: H_NEG, v_neg: V_NEG};
    localparam int HT_P = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT_P = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW+1:0] MAX_TOTAL = (CW+2)'(2 ** CW);
`ifdef VGA_TIMING_GEN_CFG_EN
    localparam logic CFG_READY_RST = 1'b1;
`else
    localparam logic CFG_READY_RST = 1'b0;
`endif

    // Totals are formed two bits wider so an oversized mode cannot alias.
    function automatic logic [CW+1:0] sum4(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c, input logic [CW-1:0] d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    // True when active+fp <= pos < active+fp+sync.
    function automatic logic in_sync(input logic [CW-1:0] pos, input logic [CW-1:0] act,
                                     input logic [CW-1:0] fp, input logic [CW-1:0] sw);
        logic [CW+1:0] lo;
        logic [CW+1:0] hi;
        lo = {2'b00, act} + {2'b00, fp};
        hi = lo + {2'b00, sw};
        return ({2'b00, pos} >= lo) && ({2'b00, pos} < hi);
    endfunction

    timing_t       act_q, act_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, picture_q, picture_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
    logic [CW+1:0] ht, vt;
    logic          x_wrap, y_wrap, tick_frame;

`ifdef VGA_TIMING_GEN_CFG_EN
    timing_t       pend_q, pend_d, new_cfg;
    logic          pend_valid_q, pend_valid_d;
    logic          new_bad, transfer;
`else
    logic          unused_cfg;
    assign unused_cfg = ^{cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_v_active,
                          cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_h_neg, cfg_v_neg, cfg_valid};
`endif

    always_comb begin
        ht         = sum4(act_q.h_active, act_q.h_fp, act_q.h_sync, act_q.h_bp);
        vt         = sum4(act_q.v_active, act_q.v_fp, act_q.v_sync, act_q.v_bp);
        x_wrap     = ({2'b00, x_q} == ht - (CW+2)'(1));
        y_wrap     = ({2'b00, y_q} == vt - (CW+2)'(1));
        tick_frame = pix_en & x_wrap & y_wrap;

        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        if (pix_en) begin
            x_d          = x_wrap ? '0 : x_q + CW'(1);
            line_start_d = x_wrap;
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + CW'(1);
            end
            if (tick_frame) begin
                frame_start_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
        end

        act_d = act_q;
`ifdef VGA_TIMING_GEN_CFG_EN
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        new_cfg      = '{h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync,
                         h_bp: cfg_h_bp, v_active: cfg_v_active, v_fp: cfg_v_fp,
                         v_sync: cfg_v_sync, v_bp: cfg_v_bp, h_neg: cfg_h_neg,
                         v_neg: cfg_v_neg};
        new_bad  = (cfg_h_active == '0) || (cfg_h_sync == '0) ||
                   (cfg_v_active == '0) || (cfg_v_sync == '0) ||
                   (sum4(cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp) > MAX_TOTAL) ||
                   (sum4(cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp) > MAX_TOTAL);
        transfer = cfg_valid & cfg_ready_q;
        // Applying and capturing never collide: ready is low while a mode is pending.
        if (tick_frame && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end
        if (transfer && !new_bad) begin
            pend_d       = new_cfg;
            pend_valid_d = 1'b1;
        end
        cfg_err_d   = transfer & new_bad;
        // Ready stays low through the applying edge and returns one clock later.
        cfg_ready_d = ~pend_valid_d & ~(tick_frame & pend_valid_q);
`else
        cfg_err_d   = 1'b0;
        cfg_ready_d = 1'b0;
`endif

        // Decode the new position against the mode that owns it, so the
        // first pixel of a reprogrammed frame already uses the new polarity.
        picture_d = (x_d < act_d.h_active) && (y_d < act_d.v_active);
        hsync_d   = in_sync(x_d, act_d.h_active, act_d.h_fp, act_d.h_sync) ^ act_d.h_neg;
        vsync_d   = in_sync(y_d, act_d.v_active, act_d.v_fp, act_d.v_sync) ^ act_d.v_neg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_q         <= PARAM_CFG;
            x_q           <= CW'(HT_P - 1);
            y_q           <= CW'(VT_P - 1);
            hsync_q       <= H_NEG;
            vsync_q       <= V_NEG;
            picture_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            cfg_ready_q   <= CFG_READY_RST;
            cfg_err_q     <= 1'b0;
`ifdef VGA_TIMING_GEN_CFG_EN
            pend_q        <= PARAM_CFG;
            pend_valid_q  <= 1'b0;
`endif
        end else begin
            act_q         <= act_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            picture_q     <= picture_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
`ifdef VGA_TIMING_GEN_CFG_EN
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
`endif
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign picture     = picture_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: small 8/2/2/2 x 4/1/1/1 raster, a pixel-index
// reference model checked every clock, plus literal checks of the key timings.
module tb_vga_timing_gen;
    localparam int CW = 4;
`ifdef VGA_TIMING_GEN_CFG_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pix_en = 1'b0;
    logic [CW-1:0] cfg_h_active = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
    logic [CW-1:0] cfg_v_active = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
    logic          cfg_h_neg = 1'b0, cfg_v_neg = 1'b0, cfg_valid = 1'b0;
    logic          cfg_ready, cfg_err, hsync, vsync, picture, line_start, frame_start;
    logic [CW-1:0] x, y;
    logic [15:0]   frame_count;

    vga_timing_gen #(
        .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_NEG(1'b0), .V_NEG(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync),
        .cfg_h_bp(cfg_h_bp), .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_h_neg(cfg_h_neg),
        .cfg_v_neg(cfg_v_neg), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .picture(picture),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Position is a single pixel index within the frame; x/y are derived from it.
    localparam int PARAMS[10] = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0};
    int mc[10];       // active mode: ha hf hs hb va vf vs vb hneg vneg
    int pc[10];       // pending mode
    int nc[10];       // mode presented on the cfg inputs
    int pos, m_fc;
    bit m_pend, m_ready, m_err, m_ls, m_fs, m_applied, m_transfer, m_pe, m_cv;

    function automatic bit mode_bad(input int c[10]);
        return c[0] == 0 || c[2] == 0 || c[4] == 0 || c[6] == 0 ||
               (c[0] + c[1] + c[2] + c[3]) > (1 << CW) ||
               (c[4] + c[5] + c[6] + c[7]) > (1 << CW);
    endfunction

    always @(posedge clock) begin
        int ht, ex, ey, ehs, evs;
        logic [30:0] exp_v, act_v;
        m_pe = pix_en;
        m_cv = cfg_valid;
        nc = '{int'(cfg_h_active), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
               int'(cfg_v_active), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp),
               int'(cfg_h_neg), int'(cfg_v_neg)};
        if (reset) begin
            mc = PARAMS;
            pos = (8 + 2 + 2 + 2) * (4 + 1 + 1 + 1) - 1;
            m_fc = 0; m_pend = 0; m_err = 0; m_ls = 0; m_fs = 0;
            m_ready = CFG_EN;
        end else begin
            m_ls = 0; m_fs = 0; m_err = 0; m_applied = 0;
            m_transfer = m_cv && m_ready;
            if (m_pe) begin
                pos = (pos + 1) % ((mc[0] + mc[1] + mc[2] + mc[3]) * (mc[4] + mc[5] + mc[6] + mc[7]));
                m_ls = (pos % (mc[0] + mc[1] + mc[2] + mc[3])) == 0;
                if (pos == 0) begin
                    m_fs = 1;
                    m_fc = (m_fc + 1) % 65536;
                    if (m_pend) begin
                        mc = pc;
                        m_pend = 0;
                        m_applied = 1;
                    end
                end
            end
            if (m_transfer) begin
                if (mode_bad(nc)) m_err = 1;
                else begin
                    pc = nc;
                    m_pend = 1;
                end
            end
            m_ready = CFG_EN && !m_pend && !m_applied;
        end
        #1;
        if (!reset) begin
            ht  = mc[0] + mc[1] + mc[2] + mc[3];
            ex  = pos % ht;
            ey  = pos / ht;
            ehs = int'((ex >= mc[0] + mc[1]) && (ex < mc[0] + mc[1] + mc[2])) ^ mc[8];
            evs = int'((ey >= mc[4] + mc[5]) && (ey < mc[4] + mc[5] + mc[6])) ^ mc[9];
            exp_v = {CW'(ex), CW'(ey), ehs[0], evs[0], (ex < mc[0]) && (ey < mc[4]),
                     m_ls, m_fs, 16'(m_fc), m_ready, m_err};
            act_v = {x, y, hsync, vsync, picture, line_start, frame_start, frame_count,
                     cfg_ready, cfg_err};
            n_checks++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model cycle %0d: got x=%0d y=%0d hs=%b vs=%b pic=%b ls=%b fs=%b fc=%0d rdy=%b err=%b required %h (got %h)",
                         cyc, x, y, hsync, vsync, picture, line_start, frame_start,
                         frame_count, cfg_ready, cfg_err, exp_v, act_v);
            end
        end
    end

    // ---------------- pixel-enable generator ----------------
    int pe_mode = 0;   // 0: always, 1: every 3rd clock, 2: random 3/4
    int pe_ph   = 0;
    initial forever begin
        @(negedge clock);
        case (pe_mode)
            0:       pix_en = 1'b1;
            1:       begin pe_ph = (pe_ph + 1) % 3; pix_en = (pe_ph == 0); end
            default: pix_en = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic wait_fs(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (frame_start) begin
                at = cyc;
                break;
            end
        end
        chk("frame_start_seen", int'(at >= 0), 1);
    endtask

    task automatic send_cfg(input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input bit hn, input bit vn);
        @(negedge clock);
        cfg_h_active = CW'(ha); cfg_h_fp = CW'(hf); cfg_h_sync = CW'(hs); cfg_h_bp = CW'(hb);
        cfg_v_active = CW'(va); cfg_v_fp = CW'(vf); cfg_v_sync = CW'(vs); cfg_v_bp = CW'(vb);
        cfg_h_neg = hn; cfg_v_neg = vn; cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int c0, a0, a1, f0, f1, f2, hold;
        int hs_cnt, hs_bad, vs_cnt, vs_bad, pic_cnt, pic_bad, ls_cnt, ls_dbl;
        bit prev_ls;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_x", int'(x), 13);
        chk("rst_y", int'(y), 6);
        chk("rst_picture", int'(picture), 0);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_cfg_ready", int'(cfg_ready), int'(CFG_EN));
        @(negedge clock);
        reset = 1'b0;

        // Continuous pix_en: first tick, sync/picture placement, frame period
        @(posedge clock); #1;
        chk("first_x", int'(x), 0);
        chk("first_y", int'(y), 0);
        chk("first_frame_start", int'(frame_start), 1);
        chk("first_picture", int'(picture), 1);
        c0 = cyc;
        hs_cnt = 0; hs_bad = 0; vs_cnt = 0; vs_bad = 0; pic_cnt = 0; pic_bad = 0;
        for (int i = 0; i < 98; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            hs_cnt  += int'(hsync);
            hs_bad  += int'(hsync && !(x == 10 || x == 11));
            vs_cnt  += int'(vsync);
            vs_bad  += int'(vsync && y != 5);
            pic_cnt += int'(picture);
            pic_bad += int'(picture && !(x < 8 && y < 4));
        end
        chk("hsync_cycles", hs_cnt, 14);
        chk("hsync_position", hs_bad, 0);
        chk("vsync_cycles", vs_cnt, 14);
        chk("vsync_position", vs_bad, 0);
        chk("picture_cycles", pic_cnt, 32);
        chk("picture_position", pic_bad, 0);
        wait_fs(200, a1);
        chk("period_full_rate", a1 - c0, 98);

        // pix_en every 3rd clock
        pe_mode = 1;
        wait_fs(400, a0);
        a1 = -1; ls_cnt = 0; ls_dbl = 0; prev_ls = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            ls_cnt += int'(line_start);
            ls_dbl += int'(line_start && prev_ls);
            prev_ls = line_start;
            if (frame_start) begin a1 = cyc; break; end
        end
        chk("period_third_rate", a1 - a0, 294);
        chk("line_starts_per_frame", ls_cnt, 7);
        chk("line_start_width", ls_dbl, 0);

        // Mid-frame reprogramming to 6/1/1/1, 3/1/1/1, active-low hsync
        pe_mode = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            if (y == 2) break;
        end
        send_cfg(6, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0);
        chk("cfg_ready_after_load", int'(cfg_ready), 0);
        wait_fs(200, f0);
        chk("new_frame_hsync_idle", int'(hsync), int'(CFG_EN));
        chk("cfg_ready_at_boundary", int'(cfg_ready), 0);
        @(posedge clock); #1;
        chk("cfg_ready_after_boundary", int'(cfg_ready), int'(CFG_EN));
        wait_fs(200, f1);
        chk("period_new_mode", f1 - f0, CFG_EN ? 54 : 98);

        // Rejections: h_sync = 0, HT = 17; then HT = 16 accepted (stays pending)
        send_cfg(8, 2, 0, 2, 4, 1, 1, 1, 1'b0, 1'b0);
        chk("err_hsync0", int'(cfg_err), int'(CFG_EN));
        chk("ready_hsync0", int'(cfg_ready), int'(CFG_EN));
        @(negedge clock);
        chk("err_clears", int'(cfg_err), 0);
        send_cfg(8, 2, 2, 5, 4, 1, 1, 1, 1'b0, 1'b0);
        chk("err_ht17", int'(cfg_err), int'(CFG_EN));
        send_cfg(8, 2, 2, 4, 4, 1, 1, 1, 1'b0, 1'b0);
        chk("err_ht16", int'(cfg_err), 0);
        chk("ready_ht16", int'(cfg_ready), 0);

        // Asynchronous reset mid-frame with a mode pending
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("arst_x", int'(x), 13);
        chk("arst_y", int'(y), 6);
        chk("arst_picture", int'(picture), 0);
        chk("arst_frame_count", int'(frame_count), 0);
        chk("arst_cfg_ready", int'(cfg_ready), int'(CFG_EN));
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Load on the wrap tick itself: applies one frame later
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (x == 13 && y == 6) break;
        end
        send_cfg(6, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        chk("wrap_load_frame_start", int'(frame_start), 1);
        chk("wrap_load_ready", int'(cfg_ready), 0);
        f0 = cyc;
        wait_fs(200, f1);
        chk("wrap_load_old_period", f1 - f0, 98);
        wait_fs(200, f2);
        chk("wrap_load_new_period", f2 - f1, CFG_EN ? 54 : 98);

        // Randomized traffic against the model
        pe_mode = 2;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (hold > 0) begin
                hold--;
            end else begin
                cfg_h_active = CW'($urandom_range(0, 5)); cfg_h_fp = CW'($urandom_range(0, 5));
                cfg_h_sync   = CW'($urandom_range(0, 5)); cfg_h_bp = CW'($urandom_range(0, 5));
                cfg_v_active = CW'($urandom_range(0, 5)); cfg_v_fp = CW'($urandom_range(0, 5));
                cfg_v_sync   = CW'($urandom_range(0, 5)); cfg_v_bp = CW'($urandom_range(0, 5));
                cfg_h_neg    = 1'($urandom_range(0, 1));  cfg_v_neg = 1'($urandom_range(0, 1));
                cfg_valid    = ($urandom_range(0, 24) == 0);
                if (cfg_valid) hold = $urandom_range(0, 2);
            end
        end
        cfg_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
